// File: rtl/plru_tracker_pkg.sv
// Shared types and helpers for the tree pseudo-LRU tracker.
// Provides the FSM state encoding, a log2 helper and the widest tree vector.
package plru_pkg;

    localparam int MAX_WAYS = 16;

    typedef logic [MAX_WAYS-2:0] plru_tree_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } plru_state_e;

    function automatic int plru_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_tracker_if.sv
// Controller <-> PLRU tracker bundle: lookup/victim, touch and flush/init status.
// master = cache controller side, slave = tracker side.
interface plru_tracker_if #(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4
);
    logic                       flush_req;
    logic                       init_done;
    logic                       lookup_valid;
    logic [S_INDEX-1:0]         lookup_set;
    logic                       victim_valid;
    logic [$clog2(WAYS)-1:0]    victim_way;
    logic                       touch_valid;
    logic [S_INDEX-1:0]         touch_set;
    logic [$clog2(WAYS)-1:0]    touch_way;

    modport master (
        output flush_req, lookup_valid, lookup_set, touch_valid, touch_set, touch_way,
        input  init_done, victim_valid, victim_way
    );

    modport slave (
        input  flush_req, lookup_valid, lookup_set, touch_valid, touch_set, touch_way,
        output init_done, victim_valid, victim_way
    );
endinterface

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU kernel: victim walk of a tree, and the tree after marking a way MRU.
// Node i has children 2i+1 / 2i+2; a 0 bit means the victim lies in the left subtree.
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]          tree,
    input  logic [$clog2(WAYS)-1:0]  way,
    output logic [$clog2(WAYS)-1:0]  victim,
    output logic [WAYS-2:0]          next_tree
);
    localparam int WL = plru_log2(WAYS);
    localparam int NW = WL + 1;
    localparam int TW = WAYS - 1;

    always_comb begin
        logic [NW-1:0] node;
        logic [TW-1:0] sel;
        node = '0;
        for (int l = 0; l < WL; l++) begin
            sel  = tree >> node;
            node = (node << 1) + NW'(1) + NW'(sel[0]);
        end
        // Leaves are numbered WAYS-1 .. 2*WAYS-2 in breadth-first order.
        victim = WL'(node - NW'(WAYS - 1));
    end

    always_comb begin
        logic [NW-1:0] node;
        logic [TW-1:0] mask;
        logic          dir;
        next_tree = tree;
        node      = '0;
        for (int l = 0; l < WL; l++) begin
            dir       = way[WL-1-l];
            mask      = TW'(1) << node;
            next_tree = dir ? (next_tree & ~mask) : (next_tree | mask);
            node      = (node << 1) + NW'(1) + NW'(dir);
        end
    end

endmodule

// File: rtl/plru_tracker.sv
// Per-set tree pseudo-LRU tracker: registered victim one cycle after a lookup, touches land at cycle end.
// Same-set touch+lookup in one cycle forwards the post-touch tree; flush restarts the zeroing sweep.
module plru_tracker
    import plru_pkg::*;
#(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4
) (
    input  logic          clk0,
    input  logic          rst0,
    plru_tracker_if.slave bus
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int WL       = plru_log2(WAYS);
    localparam int TW       = WAYS - 1;

    plru_state_e        state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;

    logic [TW-1:0] trees [NUM_SETS];

    logic          touch_acc, lookup_acc, sweep_we;
    logic [TW-1:0] touch_tree_nxt, lookup_tree;
    logic [WL-1:0] lookup_victim;
    logic [WL-1:0] touch_victim_unused;
    logic [TW-1:0] lookup_next_unused;
    logic          victim_valid_q;
    logic [WL-1:0] victim_way_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        if (bus.flush_req) begin
            state_d = INIT;
            cnt_d   = '0;
        end else if (state_q == INIT) begin
            sweep_we = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = READY;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign touch_acc  = (state_q == READY) && !bus.flush_req && bus.touch_valid;
    assign lookup_acc = (state_q == READY) && !bus.flush_req && bus.lookup_valid;

    plru_tree_logic #(.WAYS(WAYS)) u_touch (
        .tree      (trees[bus.touch_set]),
        .way       (bus.touch_way),
        .victim    (touch_victim_unused),
        .next_tree (touch_tree_nxt)
    );

    // Write-first: a same-cycle touch to the looked-up set is visible to the lookup.
    assign lookup_tree = (touch_acc && (bus.touch_set == bus.lookup_set))
                       ? touch_tree_nxt : trees[bus.lookup_set];

    plru_tree_logic #(.WAYS(WAYS)) u_lookup (
        .tree      (lookup_tree),
        .way       (bus.touch_way),
        .victim    (lookup_victim),
        .next_tree (lookup_next_unused)
    );

    // Tree storage is cleared only by the sweep, never by rst0 directly.
    always_ff @(posedge clk0) begin
        if (sweep_we && !rst0) begin
            trees[cnt_q] <= '0;
        end else if (touch_acc && !rst0) begin
            trees[bus.touch_set] <= touch_tree_nxt;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            victim_valid_q <= lookup_acc;
            if (lookup_acc) victim_way_q <= lookup_victim;
        end
    end

    assign bus.init_done    = (state_q == READY);
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;

endmodule

// File: doc/plru_tracker.md
Name: plru_tracker

Overview:
- Per-set tree pseudo-LRU replacement tracker for the set-associative cache.
- Generalises the raw LRU bit array: WAYS-parametric tree, built-in victim selection, touch (hit/fill) update, same-cycle write-to-read forwarding, and a sequential init/flush sweep.
- Sits beside the tag/data arrays. The cache controller issues lookups to get a victim and touches on every hit or fill.

Parameters:
- S_INDEX, 4, set-index width; NUM_SETS = 2**S_INDEX.
- WAYS, 4, associativity; power of two, 2..16; tree holds WAYS-1 bits per set.

Ports:
- clk0  in  1  clock
- rst0  in  1  synchronous active-high reset
- flush_req  in  1  restart init sweep (cache invalidate)
- init_done  out  1  1 = tracker ready; 0 during sweep
- lookup_valid  in  1  request victim for lookup_set
- lookup_set  in  S_INDEX  set to query
- victim_valid  out  1  victim_way valid this cycle
- victim_way  out  $clog2(WAYS)  selected victim
- touch_valid  in  1  mark touch_way most-recently-used
- touch_set  in  S_INDEX  set being touched
- touch_way  in  $clog2(WAYS)  way being touched

Behaviour:
- One clock (clk0); reset rst0 synchronous, active-high.
- Reset values: init_done=0, victim_valid=0, victim_way=0, FSM=INIT, sweep counter=0.
- Tree encoding: node i has children 2i+1 and 2i+2; leaves are ordered way 0..WAYS-1 left to right. Bit 0 = victim lies in the left subtree.
- Victim: walk from the root following the bits; the leaf reached is the victim.
- Touch: for each node on the path to touch_way, set the bit to point away (1 if touch_way is in the left subtree, else 0). Bits off the path are unchanged.
- FSM INIT:
  - Each cycle, write zero to set[counter] and increment counter.
  - After writing set NUM_SETS-1, go to READY; init_done=1 from the next cycle.
  - The sweep takes exactly NUM_SETS cycles after rst0 deasserts.
- FSM READY: service lookups and touches.
- flush_req sampled 1 (any state): next state INIT, counter=0, init_done=0 next cycle. A flush during INIT restarts the sweep from 0.
- Accepted lookup (READY, lookup_valid=1, flush_req=0) in cycle t:
  - victim_valid=1 in cycle t+1; victim_way is registered.
  - victim_valid=0 in any cycle not following an accepted lookup.
  - victim_way holds its last value when not valid.
- Accepted touch (READY, touch_valid=1, flush_req=0) in cycle t: the tree is updated at the end of cycle t.
- Forwarding: a lookup and a touch to the same set in the same cycle t → the victim is computed from the post-touch tree (write-first). Different sets → both proceed independently.
- A touch in cycle t+1 does not alter the already-registered victim_way.
- In INIT, or in the flush cycle: lookups and touches are dropped (no victim_valid, no state change).
- rst0 mid-operation: all state returns to reset values; stored trees are cleared by the ensuing sweep, not by rst0 directly.

Decomposition:
- plru_pkg: WAYS_LOG2 constant helper, typedef for the tree vector, and enum for the FSM (INIT, READY).
- Sub-module plru_tree_logic (purely combinational, parameter WAYS):
  - tree → victim
  - (tree, way) → next tree
- Instantiate plru_tree_logic twice: once for touch update, once for the forwarded lookup.
- Storage is a flop array of NUM_SETS entries in the top module.

Test Plan:
- Reset, WAYS=4, S_INDEX=4: assert rst0 1 cycle → init_done=0 for 16 cycles, then 1. Lookups during the sweep → victim_valid stays 0.
- Lookup set 3 after init → next cycle victim_valid=1, victim_way=0.
- Touch set 3 way 0, then lookup set 3 → victim 2. Touch way 2, then lookup → victim 1.
- Same-cycle touch set 5 way 0 + lookup set 5 → victim 2 (not 0). Same-cycle touch set 6 way 0 + lookup set 7 → victim 0.
- After touching several sets, flush_req in READY:
  - init_done=0 the next cycle for 16 cycles.
  - A touch in the flush cycle is dropped.
  - Every set then returns victim 0.
- WAYS=8: touch ways 0,1,2,3 in set 0, then lookup → victim 4. Touch 4..7, then lookup → victim 0.
